// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern mode controller.
// Mode encodings, mode-select width and the key FSM state type.
package vga_pkg;

  localparam int MODE_W = 4;

  localparam int MODE_BLACK   = 0;
  localparam int MODE_WHITE   = 1;
  localparam int MODE_RED     = 2;
  localparam int MODE_GREEN   = 3;
  localparam int MODE_BLUE    = 4;
  localparam int MODE_GRID_S  = 5;
  localparam int MODE_GRID_L  = 6;
  localparam int MODE_HGRAD   = 7;
  localparam int MODE_VGRAD   = 8;
  localparam int MODE_RGRAD   = 9;
  localparam int MODE_GGRAD   = 10;
  localparam int MODE_BGRAD   = 11;
  localparam int MODE_BARS    = 12;
  localparam int MODE_DEFAULT = 13;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS_DB,
    KEY_HELD,
    KEY_REL_DB
  } key_state_t;

  function automatic logic [MODE_W-1:0] next_mode(
    input logic [MODE_W-1:0] m,
    input logic [MODE_W-1:0] last
  );
    return (m == last) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Link between the timing generator / pattern mux and the mode controller.
// master = mode controller, slave = timing generator + pattern mux side.
interface vga_mode_ctrl_if;
  import vga_pkg::*;

  logic              frame_start;
  logic [MODE_W-1:0] dis_mode;
  logic              mode_changed;
  logic              auto_active;

  modport master (
    input  frame_start,
    output dis_mode,
    output mode_changed,
    output auto_active
  );

  modport slave (
    output frame_start,
    input  dis_mode,
    input  mode_changed,
    input  auto_active
  );

endinterface

// File: rtl/vga_mode_ctrl_key_debounce.sv
// Key synchroniser and press classifier.
// Emits one-cycle short_press (on accepted release) and long_press pulses.
module key_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 6500000,
  parameter int LONG_PRESS_CYC = 65000000
) (
  input  logic vga_clk,
  input  logic rstn,
  input  logic key_n,
  output logic short_press,
  output logic long_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYC);

  key_state_t        state;
  logic [1:0]        sync;
  logic              key_s;
  logic              armed;
  logic              long_flag;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  assign key_s = sync[1];

  // Sync resets to "pressed" and armed stays low until a release is seen,
  // so a key held through reset is ignored.
  always_ff @(posedge vga_clk) begin
    if (!rstn) begin
      sync        <= 2'b00;
      armed       <= 1'b0;
      state       <= KEY_IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_flag   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      sync        <= {sync[0], key_n};
      short_press <= 1'b0;
      long_press  <= 1'b0;
      unique case (state)
        KEY_IDLE: begin
          if (key_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state  <= KEY_PRESS_DB;
            db_cnt <= '0;
          end
        end
        KEY_PRESS_DB: begin
          if (key_s) begin
            state <= KEY_IDLE;
          end else if (db_cnt == DB_LAST) begin
            state     <= KEY_HELD;
            hold_cnt  <= '0;
            long_flag <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        KEY_HELD: begin
          if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST && !long_flag) begin
            long_press <= 1'b1;
            long_flag  <= 1'b1;
          end
          if (key_s) begin
            state  <= KEY_REL_DB;
            db_cnt <= '0;
          end
        end
        KEY_REL_DB: begin
          if (!key_s) begin
            state <= KEY_HELD;
          end else if (db_cnt == DB_LAST) begin
            state       <= KEY_IDLE;
            short_press <= !long_flag;
            long_flag   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Display-mode controller: key-driven stepping and auto-cycling,
// with every mode change applied on a frame boundary.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 6500000,
  parameter int LONG_PRESS_CYC = 65000000,
  parameter int NUM_MODES      = 14,
  parameter int DEFAULT_MODE   = 12,
  parameter int AUTO_FRAMES    = 120
) (
  input logic             vga_clk,
  input logic             rstn,
  input logic             key_n,
  vga_mode_ctrl_if.master mif
);

  if (NUM_MODES < 2 || NUM_MODES > 16 ||
      DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES ||
      DEBOUNCE_CYC < 2 || LONG_PRESS_CYC < 1 || AUTO_FRAMES < 1) begin : g_bad_param
    $error("vga_mode_ctrl: illegal parameter set");
  end

  localparam int FC_W = $clog2(AUTO_FRAMES + 1);

  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(DEFAULT_MODE);

  logic            short_press;
  logic            long_press;
  logic            pending;
  logic [FC_W-1:0] fcnt;
  logic            auto_due;
  logic            step;

  key_debounce #(
    .DEBOUNCE_CYC   (DEBOUNCE_CYC),
    .LONG_PRESS_CYC (LONG_PRESS_CYC)
  ) u_key (
    .vga_clk     (vga_clk),
    .rstn        (rstn),
    .key_n       (key_n),
    .short_press (short_press),
    .long_press  (long_press)
  );

  assign auto_due = mif.auto_active && fcnt == FC_LAST;
  assign step     = mif.frame_start && (pending || auto_due);

  // A request landing on frame_start survives the clear and waits a frame.
  always_ff @(posedge vga_clk) begin
    if (!rstn) begin
      mif.dis_mode     <= MODE_RST;
      mif.mode_changed <= 1'b0;
      mif.auto_active  <= 1'b0;
      pending          <= 1'b0;
      fcnt             <= '0;
    end else begin
      if (long_press)
        mif.auto_active <= !mif.auto_active;
      if (short_press || !mif.auto_active)
        fcnt <= '0;
      else if (mif.frame_start)
        fcnt <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
      pending          <= short_press || (pending && !mif.frame_start);
      mif.mode_changed <= step;
      if (step)
        mif.dis_mode <= next_mode(mif.dis_mode, MODE_LAST);
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Frame-locked directed + randomized bench for vga_mode_ctrl.
// Expected behaviour comes from a per-frame model of press effects.
module tb_vga_mode_ctrl;
  import vga_pkg::*;

  localparam int DB = 16;
  localparam int LP = 200;
  localparam int AF = 3;
  localparam int NM = 14;
  localparam int DM = 12;
  localparam int FP = 500;

  logic vga_clk = 1'b0;
  logic rstn    = 1'b0;
  logic key_n   = 1'b1;

  vga_mode_ctrl_if mif();

  vga_mode_ctrl #(
    .DEBOUNCE_CYC   (DB),
    .LONG_PRESS_CYC (LP),
    .NUM_MODES      (NM),
    .DEFAULT_MODE   (DM),
    .AUTO_FRAMES    (AF)
  ) dut (
    .vga_clk (vga_clk),
    .rstn    (rstn),
    .key_n   (key_n),
    .mif     (mif)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  int exp_mode;
  int exp_auto;
  int pend;
  int fcount;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
  endtask

  task automatic model_reset();
    exp_mode = DM;
    exp_auto = 0;
    pend     = 0;
    fcount   = 0;
  endtask

  // 0 idle, 1 short, 2 long, 3 bounce, 4 two shorts
  function automatic logic key_level(input int kind, input int len,
                                     input int c);
    case (kind)
      1, 2: return !(c >= 10 && c < 10 + len);
      3:    return !((c >= 10 && c < 20) || (c >= 23 && c < 33));
      4:    return !((c >= 10 && c < 10 + len) ||
                     (c >= 200 && c < 200 + len));
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input int kind, input int len);
    int step;
    int glitch;
    tick();
    mif.frame_start = 1'b1;
    step = (pend != 0 || (exp_auto != 0 && fcount == AF - 1)) ? 1 : 0;
    if (exp_auto != 0)
      fcount = (fcount == AF - 1) ? 0 : fcount + 1;
    if (step != 0)
      exp_mode = (exp_mode + 1) % NM;
    pend = 0;
    tick();
    mif.frame_start = 1'b0;
    chk("dis_mode_at_frame", mif.dis_mode, exp_mode);
    chk("mode_changed_at_frame", mif.mode_changed, step);
    glitch = 0;
    key_n = key_level(kind, len, 1);
    for (int c = 2; c < FP; c++) begin
      tick();
      if (mif.mode_changed !== 1'b0 || mif.dis_mode !== exp_mode[3:0])
        glitch++;
      key_n = key_level(kind, len, c);
    end
    if (kind == 1 || kind == 4) begin
      pend   = 1;
      fcount = 0;
    end
    if (kind == 2) begin
      exp_auto = 1 - exp_auto;
      if (exp_auto == 0)
        fcount = 0;
    end
    chk("auto_active_end_frame", mif.auto_active, exp_auto);
    chk("no_midframe_change", glitch, 0);
  endtask

  initial begin
    int kind;
    int len;
    int bad;
    mif.frame_start = 1'b0;
    model_reset();
    repeat (5) tick();
    chk("rst_dis_mode", mif.dis_mode, DM);
    chk("rst_mode_changed", mif.mode_changed, 0);
    chk("rst_auto_active", mif.auto_active, 0);
    rstn = 1'b1;

    repeat (5) run_frame(0, 0);

    run_frame(1, 40);
    run_frame(0, 0);
    run_frame(1, $urandom_range(30, 120));
    run_frame(0, 0);

    run_frame(3, 0);
    run_frame(0, 0);
    run_frame(4, $urandom_range(30, 120));
    run_frame(0, 0);

    run_frame(2, 300);
    repeat (7) run_frame(0, 0);
    run_frame(2, $urandom_range(260, 320));
    repeat (4) run_frame(0, 0);

    run_frame(2, 300);
    for (int i = 0; i < AF && fcount != AF - 1; i++)
      run_frame(0, 0);
    run_frame(1, 60);
    repeat (5) run_frame(0, 0);
    run_frame(2, 280);

    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 5);
      if (kind == 5) kind = 1;
      len = (kind == 2) ? $urandom_range(260, 320) :
                          $urandom_range(30, 120);
      run_frame(kind, len);
    end
    run_frame(0, 0);

    if (exp_mode == DM) begin
      run_frame(1, 50);
      run_frame(0, 0);
    end
    tick();
    key_n = 1'b0;
    repeat (170) tick();
    rstn = 1'b0;
    repeat (3) tick();
    model_reset();
    chk("midpress_rst_dis_mode", mif.dis_mode, DM);
    chk("midpress_rst_mode_changed", mif.mode_changed, 0);
    chk("midpress_rst_auto_active", mif.auto_active, 0);
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (mif.mode_changed !== 1'b0 || mif.auto_active !== 1'b0 ||
          mif.dis_mode !== 4'(DM))
        bad++;
    end
    chk("held_through_reset_ignored", bad, 0);
    repeat (2) run_frame(0, 0);
    run_frame(1, 50);
    run_frame(0, 0);
    chk("press_after_rearm", mif.dis_mode, (DM + 1) % NM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
